// File: rtl/smart_aqua.sv
// Coin-operated water dispenser controller: 5 L / 10 L products, coin credit, change and display digits.
// Optional cancel/refund behaviour is enabled by defining AQUA_CANCEL_EN.
module smart_aqua #(
  parameter int PRICE5  = 15,
  parameter int PRICE10 = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Liters5,
  input  logic       Liters10,
  input  logic [1:0] in,
  output logic       out1,
  output logic       out2,
  output logic [3:0] change,
  output logic [2:0] Digit0,
  output logic [2:0] Digit1
);

  localparam logic [5:0] P5_C  = 6'(PRICE5);
  localparam logic [5:0] P10_C = 6'(PRICE10);

`ifdef AQUA_CANCEL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DISPENSE = 2'd2, REFUND = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DISPENSE = 2'd2} state_t;
`endif

  state_t     state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic [5:0] price_q, price_d;
  logic       prod10_q, prod10_d;
  logic       out1_q, out1_d;
  logic       out2_q, out2_d;
  logic [3:0] change_q, change_d;
  logic [2:0] dig0_q, dig0_d;
  logic [2:0] dig1_q, dig1_d;

  logic [5:0] coin_s;
  logic [5:0] new_credit_s;
  logic [5:0] diff_s;
  logic       cancel_s;

  always_comb begin
    case (in)
      2'b01:   coin_s = 6'd5;
      2'b10:   coin_s = 6'd10;
      2'b11:   coin_s = 6'd20;
      default: coin_s = 6'd0;
    endcase
  end

  assign new_credit_s = credit_q + coin_s;
  assign diff_s       = new_credit_s - price_q;
`ifdef AQUA_CANCEL_EN
  assign cancel_s = ~Liters5 & ~Liters10;
`else
  assign cancel_s = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    prod10_d = prod10_q;
    out1_d   = 1'b0;
    out2_d   = 1'b0;
    change_d = 4'd0;
    dig0_d   = 3'd0;
    dig1_d   = 3'd0;
    case (state_q)
      IDLE: begin
        credit_d = 6'd0;
        if (Liters10) begin
          state_d  = COLLECT;
          price_d  = P10_C;
          prod10_d = 1'b1;
          dig1_d   = 3'(P10_C / 6'd5);
        end else if (Liters5) begin
          state_d  = COLLECT;
          price_d  = P5_C;
          prod10_d = 1'b0;
          dig1_d   = 3'(P5_C / 6'd5);
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (cancel_s) begin
          // Cancel ignores any coin this cycle; zero credit needs no refund cycle
          credit_d = 6'd0;
`ifdef AQUA_CANCEL_EN
          if (credit_q != 6'd0) begin
            state_d  = REFUND;
            change_d = credit_q[3:0];
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (new_credit_s >= price_q) begin
          state_d  = DISPENSE;
          credit_d = 6'd0;
          change_d = diff_s[3:0];
          out1_d   = ~prod10_q;
          out2_d   = prod10_q;
        end else begin
          credit_d = new_credit_s;
          dig0_d   = 3'(new_credit_s / 6'd5);
          dig1_d   = 3'((price_q - new_credit_s) / 6'd5);
        end
      end
      DISPENSE: begin
        state_d = IDLE;
      end
`ifdef AQUA_CANCEL_EN
      REFUND: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d  = IDLE;
        credit_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= 6'd0;
      price_q  <= 6'd0;
      prod10_q <= 1'b0;
      out1_q   <= 1'b0;
      out2_q   <= 1'b0;
      change_q <= 4'd0;
      dig0_q   <= 3'd0;
      dig1_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      prod10_q <= prod10_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      change_q <= change_d;
      dig0_q   <= dig0_d;
      dig1_q   <= dig1_d;
    end
  end

  assign out1   = out1_q;
  assign out2   = out2_q;
  assign change = change_q;
  assign Digit0 = dig0_q;
  assign Digit1 = dig1_q;

endmodule

// File: tb/tb_smart_aqua.sv
// Directed bench for smart_aqua: expected outputs are queued with each stimulus step and checked after the edge.
module tb_smart_aqua;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Liters5 = 1'b0;
  logic       Liters10 = 1'b0;
  logic [1:0] in = 2'b00;
  logic       out1, out2;
  logic [3:0] change;
  logic [2:0] Digit0, Digit1;

  typedef struct packed {
    logic       o1;
    logic       o2;
    logic [3:0] ch;
    logic [2:0] d0;
    logic [2:0] d1;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  smart_aqua #(.PRICE5(15), .PRICE10(30)) dut (
    .clk(clk), .reset(reset), .Liters5(Liters5), .Liters10(Liters10), .in(in),
    .out1(out1), .out2(out2), .change(change), .Digit0(Digit0), .Digit1(Digit1)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic rst, input logic l5, input logic l10,
                      input logic [1:0] c, input logic o1, input logic o2,
                      input logic [3:0] ch, input logic [2:0] d0, input logic [2:0] d1);
    exp_t e;
    exp_t obs;
    reset    = rst;
    Liters5  = l5;
    Liters10 = l10;
    in       = c;
    sb.push_back({o1, o2, ch, d0, d1});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {out1, out2, change, Digit0, Digit1};
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed out1=%b out2=%b change=%0d d0=%0d d1=%0d expected out1=%b out2=%b change=%0d d0=%0d d1=%0d",
             tag, obs.o1, obs.o2, obs.ch, obs.d0, obs.d1, e.o1, e.o2, e.ch, e.d0, e.d1);
    end
    tests++;
    assert (!(out1 && out2)) else begin
      fails++;
      $error("FAIL %s_onehot: observed out1=%b out2=%b expected not both high", tag, out1, out2);
    end
  endtask

  initial begin
    // reset with random inputs
    step("rst0", 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    step("rst1", 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    // 5 L: 5 + 10 exact
    step("a_sel",  1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd3);
    step("a_c5",   1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 3'd1, 3'd2);
    step("a_c10",  1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0);
    step("a_idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    // 10 L: three 10 Rs coins
    step("b_sel",  1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd6);
    step("b_c1",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd2, 3'd4);
    step("b_c2",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd4, 3'd2);
    step("b_c3",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'd0, 3'd0, 3'd0);
    step("b_idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    // 5 L overpaid: 10 + 20 -> change 15
    step("c_sel",  1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd3);
    step("c_c10",  1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 3'd2, 3'd1);
    step("c_c20",  1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 4'd15, 3'd0, 3'd0);
    step("c_idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    // 10 L: credit 25 then 20 -> change 15
    step("d_sel",  1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd6);
    step("d_c1",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd2, 3'd4);
    step("d_c2",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd4, 3'd2);
    step("d_c3",   1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'd0, 3'd5, 3'd1);
    step("d_c4",   1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 4'd15, 3'd0, 3'd0);
    step("d_idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    // both selections: 10 L wins
    step("e_sel",  1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd6);
    step("e_c1",   1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd2, 3'd4);
    step("e_c2",   1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd4, 3'd2);
    step("e_c3",   1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'd0, 3'd0, 3'd0);
    step("e_idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    // coins in IDLE ignored
    step("f_idlec", 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    step("f_sel",   1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd3);
    // 20 into 5 L -> change 5; selection held, coin during dispense ignored, restart
    step("g_c20",   1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 4'd5, 3'd0, 3'd0);
    step("g_disp",  1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    step("g_rest",  1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd3);
    // a held 5 Rs coin counts every cycle
    step("g_h1",    1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 3'd1, 3'd2);
    step("g_h2",    1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 3'd2, 3'd1);
    step("g_h3",    1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 4'd0, 3'd0, 3'd0);
    step("g_idle",  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    // selection dropped mid-collection
    step("h_sel",   1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd6);
    step("h_c10",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd2, 3'd4);
`ifdef AQUA_CANCEL_EN
    step("h_cancel", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd10, 3'd0, 3'd0);
    step("h_idle",   1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    step("h_idle2",  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    step("h_sel0",   1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd6);
    step("h_cnc0",   1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
`else
    step("h_drop",   1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd2, 3'd4);
    step("h_c5",     1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 3'd3, 3'd3);
    step("h_c20",    1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 4'd5, 3'd0, 3'd0);
    step("h_idle",   1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
`endif
    // reset mid-collection discards credit
    step("r_sel",   1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd6);
    step("r_c10",   1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd2, 3'd4);
    step("r_rst",   1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    step("r_idle",  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    step("r_sel5",  1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd3);
    step("r_c20",   1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 4'd5, 3'd0, 3'd0);
    step("r_end",   1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
